fetch_ibuf_stage: RTL and testbench

FETCH_IBUF_STAGE -- requirements
Module: fetch_ibuf_stage

---
 rtl/fetch_ibuf_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_ibuf_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ibuf_stage.sv
// Fetch stage with an in-order pc queue for outstanding instruction reads and a
// small instruction buffer feeding decode; redirects cancel in-flight responses.
module fetch_ibuf_stage #(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter int          IBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  input  logic [32:0] br_bus,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  localparam int AW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  localparam cnt_t          DEPTH_C = cnt_t'(IBUF_DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(IBUF_DEPTH);

  logic        br_taken;
  logic [31:0] br_target;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  cnt_t        live_cnt_q, live_cnt_d;
  cnt_t        cancel_cnt_q, cancel_cnt_d;
  cnt_t        buf_cnt_q, buf_cnt_d;
  ptr_t        buf_wp_q, buf_wp_d;
  ptr_t        buf_rp_q, buf_rp_d;
  ptr_t        pq_wp_q, pq_wp_d;
  ptr_t        pq_rp_q, pq_rp_d;

  logic [31:0] pq_mem_q       [IBUF_DEPTH];
  logic [31:0] buf_pc_mem_q   [IBUF_DEPTH];
  logic [31:0] buf_inst_mem_q [IBUF_DEPTH];

  logic [CW:0] live_buf_sum;
  logic [CW:0] live_cancel_sum;
  logic        req_hs;
  logic        rsp_cancel;
  logic        rsp_keep;
  logic        rsp_drop_live;
  logic        buf_push;
  logic        buf_pop;
  cnt_t        cancel_after;
  cnt_t        live_after;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  assign live_buf_sum    = {1'b0, live_cnt_q} + {1'b0, buf_cnt_q};
  assign live_cancel_sum = {1'b0, live_cnt_q} + {1'b0, cancel_cnt_q};

  // Reserving a buffer slot for every kept request makes buffer overflow impossible.
  assign inst_req  = resetn && !br_taken &&
                     (live_buf_sum < DEPTH_W) && (live_cancel_sum < DEPTH_W);
  assign inst_addr = fetch_pc_q;
  assign req_hs    = inst_req && inst_addr_ok;

  assign rsp_cancel    = inst_data_ok && (cancel_cnt_q != '0);
  assign rsp_keep      = inst_data_ok && (cancel_cnt_q == '0) && !br_taken;
  assign rsp_drop_live = inst_data_ok && (cancel_cnt_q == '0) && br_taken;

  assign fs_to_ds_valid = resetn && (buf_cnt_q != '0) && !br_taken;
  assign fs_to_ds_bus   = {buf_pc_mem_q[buf_rp_q], buf_inst_mem_q[buf_rp_q]};

  assign buf_push = rsp_keep;
  assign buf_pop  = fs_to_ds_valid && ds_allowin;

  assign cancel_after = cancel_cnt_q - cnt_t'(rsp_cancel);
  assign live_after   = live_cnt_q + cnt_t'(req_hs) - cnt_t'(rsp_keep) - cnt_t'(rsp_drop_live);

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    live_cnt_d   = live_after;
    cancel_cnt_d = cancel_after;
    buf_cnt_d    = buf_cnt_q + cnt_t'(buf_push) - cnt_t'(buf_pop);
    buf_wp_d     = buf_wp_q + ptr_t'(buf_push);
    buf_rp_d     = buf_rp_q + ptr_t'(buf_pop);
    // The pc queue keeps draining through a redirect: cancelled responses still pop it.
    pq_wp_d      = pq_wp_q + ptr_t'(req_hs);
    pq_rp_d      = pq_rp_q + ptr_t'(inst_data_ok);

    if (br_taken) begin
      fetch_pc_d   = br_target;
      cancel_cnt_d = cancel_after + live_after;
      live_cnt_d   = '0;
      buf_cnt_d    = '0;
      buf_wp_d     = '0;
      buf_rp_d     = '0;
    end else if (req_hs) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q   <= RESET_PC;
      live_cnt_q   <= '0;
      cancel_cnt_q <= '0;
      buf_cnt_q    <= '0;
      buf_wp_q     <= '0;
      buf_rp_q     <= '0;
      pq_wp_q      <= '0;
      pq_rp_q      <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      live_cnt_q   <= live_cnt_d;
      cancel_cnt_q <= cancel_cnt_d;
      buf_cnt_q    <= buf_cnt_d;
      buf_wp_q     <= buf_wp_d;
      buf_rp_q     <= buf_rp_d;
      pq_wp_q      <= pq_wp_d;
      pq_rp_q      <= pq_rp_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers and counters.
  always_ff @(posedge clk) begin
    if (req_hs) begin
      pq_mem_q[pq_wp_q] <= fetch_pc_q;
    end
    if (buf_push) begin
      buf_pc_mem_q[buf_wp_q]   <= pq_mem_q[pq_rp_q];
      buf_inst_mem_q[buf_wp_q] <= inst_rdata;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(buf_push && !buf_pop && (buf_cnt_q == DEPTH_C)))
    else $error("instruction buffer overflow");

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!resetn)
    !(inst_data_ok && (live_cancel_sum == '0)))
    else $error("inst_data_ok with no outstanding request");

endmodule

// File: tb/tb_fetch_ibuf_stage.sv
// Scoreboard bench for fetch_ibuf_stage: in-order memory model, expected bundles
// queued at request acceptance, monitor compares every bundle taken by decode.
module tb_fetch_ibuf_stage;
  localparam logic [31:0] RPC   = 32'h1c000000;
  localparam int          DEPTH = 4;

  logic        clk;
  logic        resetn;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic [32:0] br_bus;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  fetch_ibuf_stage #(.RESET_PC(RPC), .IBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .br_bus(br_bus), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          ao_rand = 0;
  bit          ao_val = 1;
  bit          dok_rand = 0;
  mreq_t       mq[$];
  logic [63:0] sb[$];
  logic [31:0] dlog[$];
  logic [31:0] exp_addr = RPC;
  int          hs_cnt = 0;
  int          dlv_cnt = 0;

  function automatic logic [31:0] f_inst(input logic [31:0] pc);
    return pc ^ 32'hdeadbeef;
  endfunction

  function automatic logic [31:0] dl(input int i);
    if (i < dlog.size()) return dlog[i];
    return 32'hxxxxxxxx;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: in-order responses, lat cycles after acceptance, optional random stalls.
  initial begin
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      inst_data_ok = 1'b0;
      if (!resetn) begin
        mq.delete();
        inst_addr_ok = 1'b0;
      end else begin
        inst_addr_ok = ao_rand ? 1'($urandom_range(0, 1)) : ao_val;
        if (mq.size() > 0 && mq[0].due <= cyc &&
            (!dok_rand || $urandom_range(0, 2) != 0)) begin
          inst_data_ok = 1'b1;
          inst_rdata   = f_inst(mq[0].addr);
        end
      end
    end
  end

  // Monitor and scoreboard, sampled mid-cycle for the upcoming edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        sb.delete();
        mq.delete();
        exp_addr = RPC;
      end else begin
        if (fs_to_ds_valid && ds_allowin) begin
          dlv_cnt++;
          dlog.push_back(fs_to_ds_bus[63:32]);
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL deliver_unexpected: got %h, expected no bundle", fs_to_ds_bus);
          end else begin
            chk("deliver", fs_to_ds_bus, sb.pop_front());
          end
        end
        if (inst_data_ok) begin
          if (mq.size() > 0) void'(mq.pop_front());
        end
        if (inst_req && inst_addr_ok) begin
          chk("fetch_addr", {32'h0, inst_addr}, {32'h0, exp_addr});
          sb.push_back({exp_addr, f_inst(exp_addr)});
          mq.push_back('{addr: inst_addr, due: cyc + lat});
          exp_addr = exp_addr + 32'd4;
          hs_cnt++;
        end
        if (br_bus[32]) begin
          sb.delete();
          exp_addr = br_bus[31:0];
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int l, input bit allow);
    resetn     = 1'b0;
    br_bus     = '0;
    lat        = l;
    ao_rand    = 0;
    dok_rand   = 0;
    ao_val     = 1;
    ds_allowin = allow;
    tick(3);
    dlog.delete();
    hs_cnt = 0;
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d0;
    int          k;
    logic [31:0] rt;
    bit          prev_br;

    resetn     = 1'b0;
    ds_allowin = 1'b1;
    br_bus     = '0;
    tick(3);
    at_neg();
    chk("reset_inst_req", 64'(inst_req), 64'd0);
    chk("reset_valid", 64'(fs_to_ds_valid), 64'd0);
    chk("reset_addr", {32'h0, inst_addr}, {32'h0, RPC});
    @(posedge clk);
    #1;
    dlog.delete();
    resetn = 1'b1;
    at_neg();
    chk("release_inst_req", 64'(inst_req), 64'd1);
    chk("release_addr", {32'h0, inst_addr}, {32'h0, RPC});

    // Streaming: one bundle per cycle once filled.
    @(posedge clk);
    #1;
    tick(12);
    chk("stream_pc0", {32'h0, dl(0)}, 64'h1c000000);
    chk("stream_pc1", {32'h0, dl(1)}, 64'h1c000004);
    chk("stream_pc2", {32'h0, dl(2)}, 64'h1c000008);
    chk("stream_pc3", {32'h0, dl(3)}, 64'h1c00000c);
    chk("stream_pc4", {32'h0, dl(4)}, 64'h1c000010);
    d0 = dlv_cnt;
    tick(8);
    chk("stream_throughput", 64'(dlv_cnt - d0), 64'd8);

    // Decode stalled: exactly DEPTH requests, then drain in order.
    do_reset(1, 1'b0);
    tick(15);
    at_neg();
    chk("stall_hs_count", 64'(hs_cnt), 64'd4);
    chk("stall_inst_req", 64'(inst_req), 64'd0);
    chk("stall_valid", 64'(fs_to_ds_valid), 64'd1);
    @(posedge clk);
    #1;
    ds_allowin = 1'b1;
    tick(10);
    chk("drain_pc0", {32'h0, dl(0)}, 64'h1c000000);
    chk("drain_pc1", {32'h0, dl(1)}, 64'h1c000004);
    chk("drain_pc2", {32'h0, dl(2)}, 64'h1c000008);
    chk("drain_pc3", {32'h0, dl(3)}, 64'h1c00000c);
    chk("drain_pc4", {32'h0, dl(4)}, 64'h1c000010);
    chk("drain_resume", 64'(hs_cnt > 4), 64'd1);

    // Redirect with two requests in flight (latency 3).
    do_reset(3, 1'b1);
    tick(2);
    ao_val = 0;
    br_bus = {1'b1, 32'h1c000100};
    at_neg();
    chk("redir_hs_count", 64'(hs_cnt), 64'd2);
    chk("redir_inst_req", 64'(inst_req), 64'd0);
    chk("redir_valid", 64'(fs_to_ds_valid), 64'd0);
    @(posedge clk);
    #1;
    br_bus = '0;
    ao_val = 1;
    tick(14);
    chk("redir_first_pc", {32'h0, dl(0)}, 64'h1c000100);
    chk("redir_second_pc", {32'h0, dl(1)}, 64'h1c000104);

    // Redirect coincident with a response landing on a nearly full buffer.
    do_reset(1, 1'b0);
    k = 0;
    tick(1);
    while (hs_cnt < 4 && k < 20) begin
      tick(1);
      k++;
    end
    if (k >= 20) begin
      n_chk++;
      n_fail++;
      $display("FAIL fill_timeout: got %0d requests, expected 4", hs_cnt);
    end
    br_bus     = {1'b1, 32'h1c000200};
    ds_allowin = 1'b1;
    at_neg();
    chk("coinc_data_ok", 64'(inst_data_ok), 64'd1);
    chk("coinc_valid", 64'(fs_to_ds_valid), 64'd0);
    @(posedge clk);
    #1;
    br_bus = '0;
    at_neg();
    chk("coinc_empty_after", 64'(fs_to_ds_valid), 64'd0);
    @(posedge clk);
    #1;
    tick(8);
    chk("coinc_first_pc", {32'h0, dl(0)}, 64'h1c000200);

    // Asynchronous reset mid-burst.
    do_reset(1, 1'b1);
    tick(6);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_inst_req", 64'(inst_req), 64'd0);
    chk("async_valid", 64'(fs_to_ds_valid), 64'd0);
    chk("async_addr", {32'h0, inst_addr}, {32'h0, RPC});
    tick(2);
    dlog.delete();
    resetn = 1'b1;
    tick(8);
    chk("restart_pc0", {32'h0, dl(0)}, {32'h0, RPC});
    chk("restart_pc1", {32'h0, dl(1)}, {32'h0, RPC + 32'd4});

    // Random stalls and redirects.
    do_reset(2, 1'b1);
    ao_rand  = 1;
    dok_rand = 1;
    prev_br  = 0;
    d0       = dlv_cnt;
    for (int i = 0; i < 3000; i++) begin
      ds_allowin = 1'($urandom_range(0, 1));
      if (!prev_br && $urandom_range(0, 29) == 0) begin
        rt = $urandom;
        rt[1:0] = 2'b00;
        br_bus  = {1'b1, rt};
        prev_br = 1;
      end else begin
        br_bus  = '0;
        prev_br = 0;
      end
      tick(1);
    end
    br_bus     = '0;
    ds_allowin = 1'b1;
    ao_rand    = 0;
    ao_val     = 0;
    dok_rand   = 0;
    tick(40);
    chk("random_drained", 64'(sb.size()), 64'd0);
    chk("random_activity", 64'((dlv_cnt - d0) > 200), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
